// File: rtl/fifo_fwft_adapter.sv
// Read-domain adapter: drives a 1-cycle-latency FIFO pop port and re-presents the words as a FWFT valid/ready stream.
// Optional FWFT_STATS_EN adds saturating stat_words / stat_stall counters.
module fifo_fwft_adapter #(
  parameter int BITS  = 32,
  parameter int DEPTH = 2
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  output logic                       fifo_rd_en,
  input  logic                       fifo_rd_empty,
  input  logic [BITS-1:0]            fifo_rd_data,
  input  logic                       flush,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BITS-1:0]            m_data,
  output logic [$clog2(DEPTH+1)-1:0] level
`ifdef FWFT_STATS_EN
  ,
  output logic [31:0]                stat_words,
  output logic [31:0]                stat_stall
`endif
);

  localparam int LW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);

  logic [BITS-1:0] mem [DEPTH];
  logic [PW-1:0]   head, tail;
  logic [LW-1:0]   cnt;
  logic            inflight;
  logic            out_fire;
  logic [LW:0]     occ;

  // Wrap at DEPTH explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    logic [PW:0] s;
    s = {1'b0, p} + 1'b1;
    return (s == (PW+1)'(DEPTH)) ? '0 : s[PW-1:0];
  endfunction

  assign m_valid  = (cnt != '0);
  assign m_data   = mem[head];
  assign level    = cnt;
  assign out_fire = m_valid & m_ready;

  // Buffered plus in-flight words after this cycle's departure must leave room for one more.
  assign occ        = (LW+1)'(cnt) + (LW+1)'(inflight) - (LW+1)'(out_fire);
  assign fifo_rd_en = !rd_rst & !fifo_rd_empty & !flush & (occ < (LW+1)'(DEPTH));

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      cnt      <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      cnt      <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (inflight) begin
        mem[tail] <= fifo_rd_data;
        tail      <= nxt(tail);
      end
      if (out_fire) head <= nxt(head);
      case ({inflight, out_fire})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef FWFT_STATS_EN
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (out_fire && stat_words != 32'hFFFF_FFFF) stat_words <= stat_words + 1'b1;
      if (m_valid && !m_ready && stat_stall != 32'hFFFF_FFFF) stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(inflight && !flush && cnt == LW'(DEPTH) && !out_fire));
  a_no_pop_empty: assert property (@(posedge rd_clk) disable iff (rd_rst)
    !(fifo_rd_en && fifo_rd_empty));
`endif

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Directed bench: behavioural 1-cycle-latency FIFO feeding the adapter, hand-computed expectations.
module tb_fifo_fwft_adapter;
  localparam int BITS  = 32;
  localparam int DEPTH = 2;

  logic            rd_clk = 1'b0;
  logic            rd_rst = 1'b1;
  logic            fifo_rd_en;
  logic            fifo_rd_empty;
  logic [BITS-1:0] fifo_rd_data = '0;
  logic            flush = 1'b0;
  logic            m_valid;
  logic            m_ready = 1'b0;
  logic [BITS-1:0] m_data;
  logic [1:0]      level;
`ifdef FWFT_STATS_EN
  logic [31:0]     stat_words, stat_stall;
`endif

  fifo_fwft_adapter #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_empty(fifo_rd_empty),
    .fifo_rd_data(fifo_rd_data), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .level(level)
`ifdef FWFT_STATS_EN
    , .stat_words(stat_words), .stat_stall(stat_stall)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: words pushed by the bench, popped with 1-cycle registered latency.
  logic [BITS-1:0] fmem [64];
  int rptr = 0, wptr = 0;
  assign fifo_rd_empty = (rptr == wptr);
  always @(posedge rd_clk)
    if (fifo_rd_en && rptr != wptr) begin
      fifo_rd_data <= fmem[rptr];
      rptr <= rptr + 1;
    end

  int n_chk = 0, n_fail = 0, viol = 0;

  always @(negedge rd_clk) begin
    #2;
    if (fifo_rd_en && fifo_rd_empty) viol++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    @(negedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [BITS-1:0] w);
    fmem[wptr] = w;
    wptr++;
  endtask

  // Collect n words with m_ready=1, comparing against base+i; returns first/last fire cycles.
  task automatic drain(input string tag, input int n, input logic [BITS-1:0] base,
                       output int first, output int last);
    int got;
    got = 0; first = -1; last = -1;
    m_ready = 1'b1;
    for (int c = 0; c < 60 && got < n; c++) begin
      #1;
      if (m_valid) begin
        chk(tag, 64'(m_data), 64'(base + BITS'(got)));
        if (first < 0) first = c;
        last = c;
        got++;
      end
      tick();
    end
    chk({tag, "_count"}, 64'(got), 64'(n));
  endtask

  int f, l, pops;

  initial begin
    tick();
    chk("rst_valid", 64'(m_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_rden", 64'(fifo_rd_en), 64'd0);
    chk("rst_data", 64'(m_data), 64'd0);
    rd_rst = 1'b0;
    tick();

    // Single word
    m_ready = 1'b1;
    push(32'hA5A5_0001);
    #1;
    chk("t1_rden_k", 64'(fifo_rd_en), 64'd1);
    tick();
    chk("t1_rden_k1", 64'(fifo_rd_en), 64'd0);
    chk("t1_valid_k1", 64'(m_valid), 64'd0);
    tick();
    chk("t1_valid_k2", 64'(m_valid), 64'd1);
    chk("t1_data", 64'(m_data), 64'hA5A5_0001);
    chk("t1_level", 64'(level), 64'd1);
    tick();
    chk("t1_level_end", 64'(level), 64'd0);
    chk("t1_valid_end", 64'(m_valid), 64'd0);

    // Streaming 0..15
    for (int i = 0; i < 16; i++) push(32'(i));
    drain("t2_data", 16, 32'd0, f, l);
    chk("t2_first_lat", 64'(f), 64'd2);
    chk("t2_back2back", 64'(l - f), 64'd15);

    // Backpressure
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(32'h200 + 32'(i));
    pops = 0;
    for (int c = 0; c < 6; c++) begin
      #1;
      if (fifo_rd_en) pops++;
      tick();
    end
    chk("t3_pops", 64'(pops), 64'd2);
    chk("t3_level", 64'(level), 64'd2);
    chk("t3_valid", 64'(m_valid), 64'd1);
    chk("t3_head", 64'(m_data), 64'h200);
    chk("t3_rden", 64'(fifo_rd_en), 64'd0);
    drain("t3_data", 8, 32'h200, f, l);
    chk("t3_level_end", 64'(level), 64'd0);

    // Release from FULL with the FIFO still supplying
    m_ready = 1'b0;
    for (int i = 0; i < 14; i++) push(32'h300 + 32'(i));
    tick(); tick(); tick();
    chk("t4_full", 64'(level), 64'd2);
    m_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #1;
      chk("t4_valid", 64'(m_valid), 64'd1);
      chk("t4_data", 64'(m_data), 64'(32'h300 + 32'(c)));
      if (c < 10) chk("t4_level", 64'(level), (c == 0) ? 64'd2 : 64'd1);
      tick();
    end
    chk("t4_level_end", 64'(level), 64'd0);

    // Flush with a word in flight
    m_ready = 1'b0;
    push(32'h400); push(32'h401); push(32'h402);
    #1;
    chk("t5_rden", 64'(fifo_rd_en), 64'd1);
    tick();
    flush = 1'b1;
    #1;
    chk("t5_flush_rden", 64'(fifo_rd_en), 64'd0);
    tick();
    flush = 1'b0;
    chk("t5_level", 64'(level), 64'd0);
    chk("t5_valid", 64'(m_valid), 64'd0);
    drain("t5_data", 2, 32'h401, f, l);

`ifdef FWFT_STATS_EN
    chk("stat_words", 64'(stat_words), 64'd41);
`endif

    // Async reset mid-stream
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h500 + 32'(i));
    tick(); tick(); tick();
    chk("t6_level_pre", 64'(level), 64'd2);
    #1;
    rd_rst = 1'b1;
    #1;
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_level", 64'(level), 64'd0);
    chk("t6_rden", 64'(fifo_rd_en), 64'd0);
`ifdef FWFT_STATS_EN
    chk("t6_stat_words", 64'(stat_words), 64'd0);
`endif
    tick();
    rd_rst = 1'b0;
    tick();

    chk("rden_while_empty", 64'(viol), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
